// File: rtl/regfile_rename_pkg.sv
// Core-wide constants shared by the Tomasulo register file and its read ports.
// Defaults match the core's register file configuration.
package regfile_rename_pkg;
    localparam int CORE_XLEN   = 32;
    localparam int CORE_NREG   = 32;
    localparam int CORE_TAG_W  = 4;
    localparam int CORE_NRD    = 2;
    localparam int CORE_REG_AW = $clog2(CORE_NREG);
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 forcing and commit-to-read bypass
// applied on top of the selected register entry.
module regfile_read_port
    import regfile_rename_pkg::*;
#(
    parameter int XLEN   = CORE_XLEN,
    parameter int TAG_W  = CORE_TAG_W,
    parameter int REG_AW = CORE_REG_AW
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [XLEN-1:0]   reg_val,
    input  logic              reg_busy,
    input  logic [TAG_W-1:0]  reg_tag,
    input  logic              commit_valid,
    input  logic [REG_AW-1:0] commit_rd,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [XLEN-1:0]   commit_val,
    output logic [XLEN-1:0]   val,
    output logic              busy,
    output logic [TAG_W-1:0]  tag
);
    logic bypass_s;

    // A commit only forwards when it is the producer the register still waits on.
    assign bypass_s = commit_valid && (commit_rd == idx) && reg_busy && (reg_tag == commit_tag);

    // Select x0 zeroes, the bypassed commit value, or the stored entry.
    always_comb begin
        val  = {XLEN{1'b0}};
        busy = 1'b0;
        tag  = {TAG_W{1'b0}};
        if (idx == {REG_AW{1'b0}}) begin
            val  = {XLEN{1'b0}};
            busy = 1'b0;
            tag  = {TAG_W{1'b0}};
        end else if (bypass_s) begin
            val  = commit_val;
            busy = 1'b0;
            tag  = reg_tag;
        end else begin
            val  = reg_val;
            busy = reg_busy;
            tag  = reg_tag;
        end
    end
endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename status (busy + RoB tag),
// commit-to-read bypass, issue-over-commit arbitration and commit-preserving flush.
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter  int XLEN   = CORE_XLEN,
    parameter  int NREG   = CORE_NREG,
    parameter  int TAG_W  = CORE_TAG_W,
    parameter  int NRD    = CORE_NRD,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  issue_valid,
    input  logic [REG_AW-1:0]     issue_rd,
    input  logic [TAG_W-1:0]      issue_tag,
    input  logic                  commit_valid,
    input  logic [REG_AW-1:0]     commit_rd,
    input  logic [TAG_W-1:0]      commit_tag,
    input  logic [XLEN-1:0]       commit_val,
    input  logic [NRD*REG_AW-1:0] rd_idx,
    output logic [NRD*XLEN-1:0]   rd_val,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag
);
    logic [XLEN-1:0]  regs_r [NREG];
    logic [NREG-1:0]  busy_r;
    logic [TAG_W-1:0] tag_r  [NREG];

    logic commit_we_s;
    logic commit_clr_s;
    logic issue_we_s;

    assign commit_we_s  = rdy_in && commit_valid && (commit_rd != {REG_AW{1'b0}});
    assign commit_clr_s = commit_we_s && busy_r[commit_rd] && (tag_r[commit_rd] == commit_tag);
    assign issue_we_s   = rdy_in && issue_valid && (issue_rd != {REG_AW{1'b0}});

    // State update: reset, then flush (keeps the flushing commit's value), then ready-gated traffic.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
                tag_r[i]  <= {TAG_W{1'b0}};
            end
            busy_r <= {NREG{1'b0}};
        end else if (flush_in) begin
            for (int i = 0; i < NREG; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
            busy_r <= {NREG{1'b0}};
            if (commit_we_s) begin
                regs_r[commit_rd] <= commit_val;
            end
        end else if (rdy_in) begin
            if (commit_we_s) begin
                regs_r[commit_rd] <= commit_val;
            end
            if (commit_clr_s) begin
                busy_r[commit_rd] <= 1'b0;
            end
            // Issue is applied last so a same-register rename overrides the commit's clear.
            if (issue_we_s) begin
                busy_r[issue_rd] <= 1'b1;
                tag_r[issue_rd]  <= issue_tag;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [REG_AW-1:0] idx_s;
        assign idx_s = rd_idx[k*REG_AW +: REG_AW];

        regfile_read_port #(
            .XLEN   (XLEN),
            .TAG_W  (TAG_W),
            .REG_AW (REG_AW)
        ) u_port (
            .idx          (idx_s),
            .reg_val      (regs_r[idx_s]),
            .reg_busy     (busy_r[idx_s]),
            .reg_tag      (tag_r[idx_s]),
            .commit_valid (commit_valid),
            .commit_rd    (commit_rd),
            .commit_tag   (commit_tag),
            .commit_val   (commit_val),
            .val          (rd_val[k*XLEN +: XLEN]),
            .busy         (rd_busy[k]),
            .tag          (rd_tag[k*TAG_W +: TAG_W])
        );
    end
endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: default configuration plus a
// 64-bit, 16-register, 3-port instance, checked through an expectation queue.
module tb_regfile_rename;
    localparam int AX = 32, AR = 32, AW = 5, AN = 2;
    localparam int BX = 64, BR = 16, BW = 4, BN = 3;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            a_rdy, a_flush, a_iv, a_cv;
    logic [AW-1:0]   a_ird, a_crd;
    logic [TW-1:0]   a_itag, a_ctag;
    logic [AX-1:0]   a_cval;
    logic [AN*AW-1:0] a_rd_idx;
    logic [AN*AX-1:0] a_rd_val;
    logic [AN-1:0]    a_rd_busy;
    logic [AN*TW-1:0] a_rd_tag;

    logic            b_rdy, b_flush, b_iv, b_cv;
    logic [BW-1:0]   b_ird, b_crd;
    logic [TW-1:0]   b_itag, b_ctag;
    logic [BX-1:0]   b_cval;
    logic [BN*BW-1:0] b_rd_idx;
    logic [BN*BX-1:0] b_rd_val;
    logic [BN-1:0]    b_rd_busy;
    logic [BN*TW-1:0] b_rd_tag;

    regfile_rename #(.XLEN(AX), .NREG(AR), .TAG_W(TW), .NRD(AN)) dut_a (
        .clk_in(clk), .rst_in(rst), .rdy_in(a_rdy), .flush_in(a_flush),
        .issue_valid(a_iv), .issue_rd(a_ird), .issue_tag(a_itag),
        .commit_valid(a_cv), .commit_rd(a_crd), .commit_tag(a_ctag), .commit_val(a_cval),
        .rd_idx(a_rd_idx), .rd_val(a_rd_val), .rd_busy(a_rd_busy), .rd_tag(a_rd_tag)
    );

    regfile_rename #(.XLEN(BX), .NREG(BR), .TAG_W(TW), .NRD(BN)) dut_b (
        .clk_in(clk), .rst_in(rst), .rdy_in(b_rdy), .flush_in(b_flush),
        .issue_valid(b_iv), .issue_rd(b_ird), .issue_tag(b_itag),
        .commit_valid(b_cv), .commit_rd(b_crd), .commit_tag(b_ctag), .commit_val(b_cval),
        .rd_idx(b_rd_idx), .rd_val(b_rd_val), .rd_busy(b_rd_busy), .rd_tag(b_rd_tag)
    );

    typedef struct {
        int          dut;
        int          port;
        string       name;
        logic [63:0] val;
        logic        busy;
        logic [3:0]  tg;
        logic        ct;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic expect_rd(input int dut, input int port, input string name,
                             input logic [63:0] v, input logic b, input logic [3:0] t, input logic ct);
        exp_t e;
        e.dut = dut; e.port = port; e.name = name;
        e.val = v; e.busy = b; e.tg = t; e.ct = ct;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [63:0] ov;
        logic        ob;
        logic [3:0]  ot;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                ov = {32'h0, a_rd_val[e.port*AX +: AX]};
                ob = a_rd_busy[e.port];
                ot = a_rd_tag[e.port*TW +: TW];
            end else begin
                ov = b_rd_val[e.port*BX +: BX];
                ob = b_rd_busy[e.port];
                ot = b_rd_tag[e.port*TW +: TW];
            end
            checks++;
            assert (ov === e.val) else begin
                errors++;
                $error("FAIL %s val observed %h expected %h", e.name, ov, e.val);
            end
            checks++;
            assert (ob === e.busy) else begin
                errors++;
                $error("FAIL %s busy observed %b expected %b", e.name, ob, e.busy);
            end
            if (e.ct) begin
                checks++;
                assert (ot === e.tg) else begin
                    errors++;
                    $error("FAIL %s tag observed %h expected %h", e.name, ot, e.tg);
                end
            end
        end
    endtask

    task automatic set_a(input int k, input logic [AW-1:0] i);
        a_rd_idx[k*AW +: AW] = i;
    endtask

    task automatic set_b(input int k, input logic [BW-1:0] i);
        b_rd_idx[k*BW +: BW] = i;
    endtask

    task automatic idle();
        a_iv = 1'b0; a_cv = 1'b0; a_flush = 1'b0;
        b_iv = 1'b0; b_cv = 1'b0; b_flush = 1'b0;
    endtask

    task automatic a_issue(input logic [AW-1:0] r, input logic [TW-1:0] t);
        a_iv = 1'b1; a_ird = r; a_itag = t;
    endtask

    task automatic a_commit(input logic [AW-1:0] r, input logic [TW-1:0] t, input logic [AX-1:0] v);
        a_cv = 1'b1; a_crd = r; a_ctag = t; a_cval = v;
    endtask

    initial begin
        rst = 1'b1;
        a_rdy = 1'b1; b_rdy = 1'b1;
        idle();
        a_ird = '0; a_itag = '0; a_crd = '0; a_ctag = '0; a_cval = '0; a_rd_idx = '0;
        b_ird = '0; b_itag = '0; b_crd = '0; b_ctag = '0; b_cval = '0; b_rd_idx = '0;

        // Reset state on both instances
        #2;
        set_a(0, 5'd5); set_a(1, 5'd31);
        expect_rd(0, 0, "rst_a0", 64'h0, 1'b0, 4'h0, 1'b1);
        expect_rd(0, 1, "rst_a1", 64'h0, 1'b0, 4'h0, 1'b1);
        set_b(0, 4'd15); set_b(1, 4'd7); set_b(2, 4'd1);
        for (int k = 0; k < BN; k++) expect_rd(1, k, "rst_b", 64'h0, 1'b0, 4'h0, 1'b1);
        check_all();
        #9 rst = 1'b0;

        // Write x5 then async reset between edges
        @(negedge clk); a_commit(5'd5, 4'h0, 32'hDEADBEEF);
        @(negedge clk); idle(); set_a(0, 5'd5);
        expect_rd(0, 0, "x5_write", 64'hDEADBEEF, 1'b0, 4'h0, 1'b1);
        check_all();
        #1 rst = 1'b1;
        expect_rd(0, 0, "x5_async_rst", 64'h0, 1'b0, 4'h0, 1'b1);
        check_all();
        rst = 1'b0;

        // Rename then bypassed commit
        @(negedge clk); a_issue(5'd3, 4'd7);
        @(negedge clk); idle(); set_a(0, 5'd3);
        expect_rd(0, 0, "x3_renamed", 64'h0, 1'b1, 4'd7, 1'b1);
        check_all();
        @(negedge clk); a_commit(5'd3, 4'd7, 32'h1234); set_a(0, 5'd3); set_a(1, 5'd3);
        expect_rd(0, 0, "x3_bypass_p0", 64'h1234, 1'b0, 4'h0, 1'b0);
        expect_rd(0, 1, "x3_bypass_p1", 64'h1234, 1'b0, 4'h0, 1'b0);
        check_all();
        @(negedge clk); idle();
        expect_rd(0, 0, "x3_committed", 64'h1234, 1'b0, 4'h0, 1'b0);
        check_all();

        // Stale commit: value written, younger rename kept, no bypass
        @(negedge clk); a_issue(5'd4, 4'd2);
        @(negedge clk); a_issue(5'd4, 4'd9);
        @(negedge clk); idle(); a_commit(5'd4, 4'd2, 32'h55); set_a(0, 5'd4);
        expect_rd(0, 0, "x4_stale_nobypass", 64'h0, 1'b1, 4'd9, 1'b1);
        check_all();
        @(negedge clk); idle();
        expect_rd(0, 0, "x4_stale_after", 64'h55, 1'b1, 4'd9, 1'b1);
        check_all();

        // Same-edge issue and commit on x6: issue wins
        @(negedge clk); a_issue(5'd6, 4'd1);
        @(negedge clk); a_issue(5'd6, 4'd3); a_commit(5'd6, 4'd1, 32'hAA); set_a(1, 5'd6);
        expect_rd(0, 1, "x6_bypass", 64'hAA, 1'b0, 4'h0, 1'b0);
        check_all();
        @(negedge clk); idle();
        expect_rd(0, 1, "x6_issue_wins", 64'hAA, 1'b1, 4'd3, 1'b1);
        check_all();

        // Flush with commit and discarded issue
        @(negedge clk); a_issue(5'd1, 4'd1);
        @(negedge clk); a_issue(5'd2, 4'd2);
        @(negedge clk); idle(); a_flush = 1'b1; a_commit(5'd1, 4'd1, 32'h77); a_issue(5'd8, 4'd5);
        @(negedge clk); idle(); set_a(0, 5'd1); set_a(1, 5'd2);
        expect_rd(0, 0, "flush_x1", 64'h77, 1'b0, 4'h0, 1'b1);
        expect_rd(0, 1, "flush_x2", 64'h0, 1'b0, 4'h0, 1'b1);
        check_all();
        set_a(0, 5'd8); set_a(1, 5'd4);
        expect_rd(0, 0, "flush_x8", 64'h0, 1'b0, 4'h0, 1'b1);
        expect_rd(0, 1, "flush_x4", 64'h55, 1'b0, 4'h0, 1'b1);
        check_all();
        set_a(0, 5'd6); set_a(1, 5'd3);
        expect_rd(0, 0, "flush_x6", 64'hAA, 1'b0, 4'h0, 1'b1);
        expect_rd(0, 1, "flush_x3", 64'h1234, 1'b0, 4'h0, 1'b1);
        check_all();

        // Flush while frozen: busy clears, commit does not write
        @(negedge clk); a_issue(5'd1, 4'd3);
        @(negedge clk); idle(); a_rdy = 1'b0; a_flush = 1'b1;
        a_commit(5'd1, 4'd3, 32'h99); a_issue(5'd9, 4'd6);
        @(negedge clk); idle(); set_a(0, 5'd1); set_a(1, 5'd9);
        expect_rd(0, 0, "frz_flush_x1", 64'h77, 1'b0, 4'h0, 1'b1);
        expect_rd(0, 1, "frz_flush_x9", 64'h0, 1'b0, 4'h0, 1'b1);
        check_all();
        @(negedge clk); a_issue(5'd10, 4'd1); a_commit(5'd5, 4'd0, 32'h11);
        @(negedge clk); idle(); set_a(0, 5'd10); set_a(1, 5'd5);
        expect_rd(0, 0, "frz_x10", 64'h0, 1'b0, 4'h0, 1'b1);
        expect_rd(0, 1, "frz_x5", 64'h0, 1'b0, 4'h0, 1'b1);
        check_all();
        a_rdy = 1'b1;

        // x0 under issue/commit traffic on both configurations
        @(negedge clk); a_issue(5'd0, 4'd4); a_commit(5'd0, 4'd4, 32'hFFFFFFFF);
        set_a(0, 5'd0); set_a(1, 5'd0);
        b_iv = 1'b1; b_ird = 4'd0; b_itag = 4'd4;
        b_cv = 1'b1; b_crd = 4'd0; b_ctag = 4'd4; b_cval = 64'hFFFFFFFFFFFFFFFF;
        set_b(0, 4'd0); set_b(1, 4'd0); set_b(2, 4'd0);
        for (int k = 0; k < AN; k++) expect_rd(0, k, "x0_a_pre", 64'h0, 1'b0, 4'h0, 1'b1);
        for (int k = 0; k < BN; k++) expect_rd(1, k, "x0_b_pre", 64'h0, 1'b0, 4'h0, 1'b1);
        check_all();
        @(negedge clk); idle();
        for (int k = 0; k < AN; k++) expect_rd(0, k, "x0_a_post", 64'h0, 1'b0, 4'h0, 1'b1);
        for (int k = 0; k < BN; k++) expect_rd(1, k, "x0_b_post", 64'h0, 1'b0, 4'h0, 1'b1);
        check_all();

        // Wide configuration: rename, bypass and write of the top register
        @(negedge clk); b_iv = 1'b1; b_ird = 4'd15; b_itag = 4'hA;
        @(negedge clk); idle(); set_b(0, 4'd15);
        expect_rd(1, 0, "b_x15_renamed", 64'h0, 1'b1, 4'hA, 1'b1);
        check_all();
        @(negedge clk); b_cv = 1'b1; b_crd = 4'd15; b_ctag = 4'hA; b_cval = 64'h0123456789ABCDEF;
        set_b(1, 4'd15); set_b(2, 4'd15);
        expect_rd(1, 1, "b_x15_bypass_p1", 64'h0123456789ABCDEF, 1'b0, 4'h0, 1'b0);
        expect_rd(1, 2, "b_x15_bypass_p2", 64'h0123456789ABCDEF, 1'b0, 4'h0, 1'b0);
        check_all();
        @(negedge clk); idle();
        expect_rd(1, 2, "b_x15_committed", 64'h0123456789ABCDEF, 1'b0, 4'h0, 1'b0);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Parametrised architectural register file with per-register rename status (busy bit + RoB tag) for the Tomasulo core.
- Successor of the fixed 32x32, 2-read register block. Adds:
  - configurable width, depth and read-port count;
  - commit-to-read bypass;
  - issue/commit same-register arbitration;
  - flush that preserves the flushing commit.
- Sits between the decoder/issue stage (reads, rename), the RoB (commit) and the RS/LSB (operand values or tags).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2); register 0 hard-wired zero
TAG_W, 4, RoB tag width
NRD, 2, number of combinational read ports
REG_AW, $clog2(NREG), derived localparam, register index width

Ports:
clk_in  in  1  system clock, all state updates on rising edge
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; low freezes all state except flush and reset
flush_in  in  1  RoB clear (mispredict); clears all rename status
issue_valid  in  1  rename request from issue stage
issue_rd  in  REG_AW  destination register being renamed
issue_tag  in  TAG_W  RoB tag allocated to the issuing instruction
commit_valid  in  1  RoB commit of a register-writing instruction
commit_rd  in  REG_AW  committed destination register
commit_tag  in  TAG_W  RoB tag of the committing entry
commit_val  in  XLEN  committed value
rd_idx  in  NRD*REG_AW  packed read indices, port k at [k*REG_AW +: REG_AW]
rd_val  out  NRD*XLEN  packed read values
rd_busy  out  NRD  1 = operand pending; use rd_tag
rd_tag  out  NRD*TAG_W  RoB tag producing the operand (valid when rd_busy)

Behaviour:
- State:
  - regs[NREG] of XLEN;
  - busy[NREG];
  - tag[NREG] of TAG_W.
- Reset (asynchronous, rst_in high): all regs = 0, busy = 0, tag = 0. Outputs then read rd_val = 0, rd_busy = 0, rd_tag = 0 for every port.
- Register 0:
  - Never written and never marked busy.
  - Reads always return val = 0, busy = 0, tag = 0, irrespective of commit or issue traffic.
- Priority per edge:
  1. rst_in
  2. flush_in
  3. rdy_in-gated normal update
  - rdy_in low with flush_in low: no state change.
- Commit, when rdy_in && commit_valid && commit_rd != 0:
  - regs[commit_rd] <= commit_val. Always applied, even if the register is renamed to a younger tag.
  - busy[commit_rd] <= 0 only when busy && tag[commit_rd] == commit_tag, and the clear is not overridden by an issue (below).
- Issue, when rdy_in && issue_valid && issue_rd != 0:
  - busy[issue_rd] <= 1 and tag[issue_rd] <= issue_tag.
  - Same edge, issue_rd == commit_rd: issue wins. Register ends busy with issue_tag, and the value is still written.
- Flush, when flush_in is high at an edge (independent of rdy_in):
  - All busy <= 0, all tag <= 0.
  - Any issue on that edge is discarded.
  - A commit on that edge still writes its value (the flushing instruction's own result is retained).
  - regs are never cleared by flush.
- Reads are combinational, one result per port, computed from pre-edge state:
  - Bypass: if commit_valid && commit_rd == idx && idx != 0 && busy[idx] && tag[idx] == commit_tag, then val = commit_val and busy = 0.
  - Otherwise val = regs[idx], busy = busy[idx], tag = tag[idx].
  - A same-cycle issue does not affect reads; sources of the issuing instruction see pre-rename state.
- Latency: write/rename visible on reads the cycle after the edge; committed value visible the same cycle via bypass.
- Multiple read ports addressing the same index return identical results.

Decomposition:
- Shared package (core-wide constants): XLEN, TAG_W, NREG, REG_AW.
- One natural sub-module, regfile_read_port, instantiated NRD times in a generate loop:
  - inputs: index, state slices, commit bus;
  - outputs: val, busy, tag;
  - contains the x0 and bypass logic.

Test Plan:
- Reset mid-run: write x5 = 0xDEADBEEF, assert rst_in asynchronously between edges -> rd_val for x5 = 0 and busy = 0 immediately, before the next edge.
- Rename/commit: issue x3 tag 7; next cycle read x3 -> busy = 1, tag = 7. Commit x3 tag 7 val 0x1234 -> same cycle rd_val = 0x1234, busy = 0 (bypass); following cycle regs[3] = 0x1234, busy = 0.
- Stale commit: issue x4 tag 2, then issue x4 tag 9, then commit x4 tag 2 val 0x55 -> regs[4] = 0x55, x4 stays busy with tag 9, and the bypass does not fire.
- Same-edge conflict: x6 busy tag 1; commit x6 tag 1 val 0xAA and issue x6 tag 3 on the same edge -> next cycle busy = 1, tag = 3, regs[6] = 0xAA.
- Flush with commit and freeze:
  - Setup: x1, x2 busy; flush_in with commit x1 tag matching val 0x77 and issue x8 tag 5 on the same edge.
  - Expected: all busy = 0, regs[1] = 0x77, x8 not busy.
  - Freeze check: repeat with rdy_in = 0 -> the flush still clears busy, but no commit write occurs.
- x0: issue x0 tag 4 and commit x0 val 0xFFFFFFFF, read x0 on all NRD ports -> val = 0, busy = 0. Repeat with NRD = 3, NREG = 16, XLEN = 64.
